// File: rtl/lane_traffic_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lane_traffic_pkg
// Description : Shared screen/road geometry constants and coordinate helpers
//               for the lane traffic engine. The geometry constants are the
//               parameter defaults of lane_traffic and lane_unit.
// Revision    : 1.0 - initial release
// ============================================================================
package lane_traffic_pkg;

    localparam int C_H_DISPLAY     = 640;
    localparam int C_V_DISPLAY     = 480;
    localparam int C_LANE_Y0       = 320;
    localparam int C_LANE_HEIGHT   = 32;
    localparam int C_CAR_WIDTH     = 64;
    localparam int C_PLAYER_WIDTH  = 32;
    localparam int C_PLAYER_HEIGHT = 32;

    // All position arithmetic is done on 11 bits so sums like x+step and
    // h+H_DISPLAY never overflow.
    typedef logic [10:0] coord_t;

    // (a - b) mod h for a, b already inside [0, h).
    function automatic coord_t wrap_diff(coord_t a, coord_t b, coord_t h);
        return (a >= b) ? (a - b) : (a + h - b);
    endfunction

endpackage
`default_nettype wire

// File: rtl/lane_traffic_lane_unit.sv
`default_nettype none
// ============================================================================
// Module      : lane_unit
// Description : One road lane. Holds the frame divider and the x positions
//               of its cars, applies wrap-around stepping, and reports
//               whether a car covers the current pixel or overlaps the
//               (latched) player rectangle.
// Ports       : clk_i, rst_n_i      - clock, async active-low reset
//               move_tick_i         - frame start while traffic is enabled
//               dir_i/step_i/div_i  - lane direction, step, frame divider
//               h_count_i/v_count_i - current pixel
//               player_x_i/_y_i     - latched player top-left corner
//               cover_o             - a car of this lane covers the pixel
//               overlap_o           - a car of this lane overlaps the player
// Revision    : 1.0 - initial release
// ============================================================================
module lane_unit
    import lane_traffic_pkg::*;
#(
    parameter int LANE_IDX      = 0,
    parameter int CARS_PER_LANE = 2,
    parameter int H_DISPLAY     = C_H_DISPLAY,
    parameter int LANE_Y0       = C_LANE_Y0,
    parameter int LANE_HEIGHT   = C_LANE_HEIGHT,
    parameter int CAR_WIDTH     = C_CAR_WIDTH,
    parameter int PLAYER_WIDTH  = C_PLAYER_WIDTH,
    parameter int PLAYER_HEIGHT = C_PLAYER_HEIGHT
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       move_tick_i,
    input  logic       dir_i,
    input  logic [5:0] step_i,
    input  logic [3:0] div_i,
    input  logic [9:0] h_count_i,
    input  logic [9:0] v_count_i,
    input  coord_t     player_x_i,
    input  coord_t     player_y_i,
    output logic       cover_o,
    output logic       overlap_o
);

    localparam coord_t C_H   = coord_t'(H_DISPLAY);
    localparam coord_t C_TOP = coord_t'(LANE_Y0 + LANE_IDX * LANE_HEIGHT);
    localparam coord_t C_BOT = coord_t'(LANE_Y0 + (LANE_IDX + 1) * LANE_HEIGHT);
    localparam coord_t C_CW  = coord_t'(CAR_WIDTH);
    localparam coord_t C_PW  = coord_t'(PLAYER_WIDTH);
    localparam coord_t C_PH  = coord_t'(PLAYER_HEIGHT);

    logic [3:0]               div_q;
    logic                     w_move;
    coord_t                   w_step;
    coord_t                   w_h;
    coord_t                   w_v;
    logic [CARS_PER_LANE-1:0] w_car_cover;
    logic [CARS_PER_LANE-1:0] w_car_hit;

    assign w_step = {5'd0, step_i};
    assign w_h    = {1'b0, h_count_i};
    assign w_v    = {1'b0, v_count_i};
    assign w_move = move_tick_i && (div_q == div_i);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            div_q <= 4'd0;
        end else if (move_tick_i) begin
            div_q <= (div_q == div_i) ? 4'd0 : div_q + 4'd1;
        end
    end

    for (genvar k = 0; k < CARS_PER_LANE; k++) begin : g_car
        coord_t x_q;
        coord_t x_d;
        coord_t w_sum;

        assign w_sum = x_q + w_step;
        assign x_d   = dir_i ? ((w_sum >= C_H) ? (w_sum - C_H) : w_sum)
                             : ((x_q < w_step) ? (x_q + C_H - w_step) : (x_q - w_step));

        always_ff @(posedge clk_i or negedge rst_n_i) begin
            if (!rst_n_i) begin
                x_q <= coord_t'(k * H_DISPLAY / CARS_PER_LANE);
            end else if (w_move) begin
                x_q <= x_d;
            end
        end

        // Span [x, x+CAR_WIDTH) taken modulo the screen width so a car
        // straddling the right edge also draws at the left edge.
        assign w_car_cover[k] = wrap_diff(w_h, x_q, C_H) < C_CW;
        assign w_car_hit[k]   = (wrap_diff(player_x_i, x_q, C_H) < C_CW) ||
                                (wrap_diff(x_q, player_x_i, C_H) < C_PW);
    end

    assign cover_o   = (w_v >= C_TOP) && (w_v < C_BOT) && (|w_car_cover);
    assign overlap_o = (player_y_i < C_BOT) && ((player_y_i + C_PH) > C_TOP) &&
                       (|w_car_hit);

endmodule
`default_nettype wire

// File: rtl/lane_traffic.sv
`default_nettype none
// ============================================================================
// Module      : lane_traffic
// Description : Road traffic engine. Instantiates one lane_unit per lane,
//               registers the car-pixel flag for the colour mux and runs a
//               per-frame, one-lane-per-cycle collision scan against the
//               player rectangle latched at frame start.
// Ports       : clk_i, rst_n_i           - pixel clock, async active-low reset
//               frame_start_i, enable_i  - frame pulse, traffic move enable
//               h_count_i, v_count_i     - current pixel
//               player_x_i, player_y_i   - player top-left corner
//               lane_dir_i/step_i/div_i  - packed per-lane controls
//               car_pixel_o              - registered car coverage flag
//               hit_o, hit_lane_o        - collision pulse and first lane
// Revision    : 1.0 - initial release
// ============================================================================
module lane_traffic
    import lane_traffic_pkg::*;
#(
    parameter int NUM_LANES     = 4,
    parameter int CARS_PER_LANE = 2,
    parameter int H_DISPLAY     = C_H_DISPLAY,
    parameter int V_DISPLAY     = C_V_DISPLAY,
    parameter int LANE_Y0       = C_LANE_Y0,
    parameter int LANE_HEIGHT   = C_LANE_HEIGHT,
    parameter int CAR_WIDTH     = C_CAR_WIDTH,
    parameter int PLAYER_WIDTH  = C_PLAYER_WIDTH,
    parameter int PLAYER_HEIGHT = C_PLAYER_HEIGHT
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic                   frame_start_i,
    input  logic                   enable_i,
    input  logic [9:0]             h_count_i,
    input  logic [9:0]             v_count_i,
    input  logic [9:0]             player_x_i,
    input  logic [9:0]             player_y_i,
    input  logic [NUM_LANES-1:0]   lane_dir_i,
    input  logic [6*NUM_LANES-1:0] lane_step_i,
    input  logic [4*NUM_LANES-1:0] lane_div_i,
    output logic                   car_pixel_o,
    output logic                   hit_o,
    output logic [2:0]             hit_lane_o
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SCAN   = 2'd1;
    localparam logic [1:0] S_REPORT = 2'd2;

    localparam logic [2:0] C_LAST_LANE = 3'(NUM_LANES - 1);
    localparam logic [9:0] C_H_VIS     = 10'(H_DISPLAY);
    localparam logic [9:0] C_V_VIS     = 10'(V_DISPLAY);

    logic [1:0]           state_q, state_d;
    logic [2:0]           idx_q, idx_d;
    logic                 found_q, found_d;
    logic [2:0]           hit_lane_q, hit_lane_d;
    logic [9:0]           px_q, py_q;
    logic                 car_pixel_q, car_pixel_d;
    logic                 w_move_tick;
    logic                 w_lane_hit;
    logic [NUM_LANES-1:0] w_cover;
    logic [NUM_LANES-1:0] w_overlap;

    assign w_move_tick = frame_start_i && enable_i;

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        lane_unit #(
            .LANE_IDX      (l),
            .CARS_PER_LANE (CARS_PER_LANE),
            .H_DISPLAY     (H_DISPLAY),
            .LANE_Y0       (LANE_Y0),
            .LANE_HEIGHT   (LANE_HEIGHT),
            .CAR_WIDTH     (CAR_WIDTH),
            .PLAYER_WIDTH  (PLAYER_WIDTH),
            .PLAYER_HEIGHT (PLAYER_HEIGHT)
        ) u_lane (
            .clk_i       (clk_i),
            .rst_n_i     (rst_n_i),
            .move_tick_i (w_move_tick),
            .dir_i       (lane_dir_i[l]),
            .step_i      (lane_step_i[l*6 +: 6]),
            .div_i       (lane_div_i[l*4 +: 4]),
            .h_count_i   (h_count_i),
            .v_count_i   (v_count_i),
            .player_x_i  ({1'b0, px_q}),
            .player_y_i  ({1'b0, py_q}),
            .cover_o     (w_cover[l]),
            .overlap_o   (w_overlap[l])
        );
    end

    // Overlap of the lane currently under scan.
    always_comb begin
        w_lane_hit = 1'b0;
        for (int l = 0; l < NUM_LANES; l++) begin
            if (idx_q == 3'(l)) begin
                w_lane_hit = w_overlap[l];
            end
        end
    end

    assign car_pixel_d = (h_count_i < C_H_VIS) && (v_count_i < C_V_VIS) && (|w_cover);

    // A frame start always wins: it restarts the scan from lane 0, which
    // also discards any scan or report still in flight.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        found_d    = found_q;
        hit_lane_d = hit_lane_q;
        if (frame_start_i) begin
            state_d    = S_SCAN;
            idx_d      = 3'd0;
            found_d    = 1'b0;
            hit_lane_d = 3'd0;
        end else begin
            case (state_q)
                S_SCAN: begin
                    if (w_lane_hit && !found_q) begin
                        found_d    = 1'b1;
                        hit_lane_d = idx_q;
                    end
                    if (idx_q == C_LAST_LANE) begin
                        state_d = S_REPORT;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
                S_REPORT: state_d = S_IDLE;
                default:  state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= S_IDLE;
            idx_q       <= 3'd0;
            found_q     <= 1'b0;
            hit_lane_q  <= 3'd0;
            px_q        <= 10'd0;
            py_q        <= 10'd0;
            car_pixel_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            found_q     <= found_d;
            hit_lane_q  <= hit_lane_d;
            car_pixel_q <= car_pixel_d;
            if (frame_start_i) begin
                px_q <= player_x_i;
                py_q <= player_y_i;
            end
        end
    end

    assign car_pixel_o = car_pixel_q;
    assign hit_o       = (state_q == S_REPORT) && found_q && !frame_start_i;
    assign hit_lane_o  = hit_lane_q;

endmodule
`default_nettype wire

// File: tb/tb_lane_traffic.sv
`default_nettype none
// ============================================================================
// Module      : tb_lane_traffic
// Description : Self-checking bench for lane_traffic with a frame-level
//               behavioural model and directed stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lane_traffic;

    localparam int NL  = 4;
    localparam int CPL = 2;
    localparam int H   = 640;
    localparam int V   = 480;
    localparam int LY0 = 320;
    localparam int LH  = 32;
    localparam int CW  = 64;
    localparam int PW  = 32;
    localparam int PH  = 32;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            frame_start;
    logic            enable;
    logic [9:0]      h_count, v_count, player_x, player_y;
    logic [NL-1:0]   lane_dir;
    logic [6*NL-1:0] lane_step;
    logic [4*NL-1:0] lane_div;
    logic            car_pixel_o, hit_o;
    logic [2:0]      hit_lane_o;

    int step_a [NL];
    int div_a  [NL];

    int checks = 0;
    int errors = 0;
    logic chk_en = 1'b0;

    always #5 clk = ~clk;

    always_comb begin
        lane_step = '0;
        lane_div  = '0;
        for (int l = 0; l < NL; l++) begin
            lane_step[l*6 +: 6] = 6'(step_a[l]);
            lane_div[l*4 +: 4]  = 4'(div_a[l]);
        end
    end

    lane_traffic dut (
        .clk_i         (clk),
        .rst_n_i       (rst_n),
        .frame_start_i (frame_start),
        .enable_i      (enable),
        .h_count_i     (h_count),
        .v_count_i     (v_count),
        .player_x_i    (player_x),
        .player_y_i    (player_y),
        .lane_dir_i    (lane_dir),
        .lane_step_i   (lane_step),
        .lane_div_i    (lane_div),
        .car_pixel_o   (car_pixel_o),
        .hit_o         (hit_o),
        .hit_lane_o    (hit_lane_o)
    );

    task automatic check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    int mx   [NL][CPL];
    int mcnt [NL];
    int exp_pixel;
    int cd;
    int hexp;
    int elane;

    function automatic int mod_h(int a);
        return ((a % H) + H) % H;
    endfunction

    function automatic int pixel_model(int h, int v, input int p [NL][CPL]);
        if (h >= H || v >= V) return 0;
        for (int l = 0; l < NL; l++)
            if (v >= LY0 + l*LH && v < LY0 + (l+1)*LH)
                for (int k = 0; k < CPL; k++)
                    if (mod_h(h - p[l][k]) < CW) return 1;
        return 0;
    endfunction

    function automatic int collide(int px, int py, input int p [NL][CPL]);
        for (int l = 0; l < NL; l++)
            if (py < LY0 + (l+1)*LH && py + PH > LY0 + l*LH)
                for (int k = 0; k < CPL; k++)
                    if (mod_h(px - p[l][k]) < CW || mod_h(p[l][k] - px) < PW)
                        return l;
        return -1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int l = 0; l < NL; l++) begin
                for (int k = 0; k < CPL; k++) mx[l][k] <= k * H / CPL;
                mcnt[l] <= 0;
            end
            exp_pixel <= 0;
            cd        <= 0;
            hexp      <= 0;
            elane     <= 0;
        end else begin
            automatic int nx [NL][CPL];
            automatic int nc [NL];
            automatic int lane;
            nx = mx;
            nc = mcnt;
            exp_pixel <= pixel_model(int'(h_count), int'(v_count), mx);
            cd <= (cd > 0) ? cd - 1 : 0;
            if (frame_start) begin
                if (enable) begin
                    for (int l = 0; l < NL; l++) begin
                        if (nc[l] == div_a[l]) begin
                            nc[l] = 0;
                            for (int k = 0; k < CPL; k++)
                                nx[l][k] = lane_dir[l] ? mod_h(nx[l][k] + step_a[l])
                                                       : mod_h(nx[l][k] - step_a[l]);
                        end else begin
                            nc[l] = (nc[l] + 1) % 16;
                        end
                    end
                end
                lane  = collide(int'(player_x), int'(player_y), nx);
                hexp  <= (lane >= 0) ? 1 : 0;
                elane <= (lane >= 0) ? lane : 0;
                cd    <= NL + 1;
            end
            mx   <= nx;
            mcnt <= nc;
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            automatic int eh;
            eh = (cd == 1 && hexp != 0 && !frame_start) ? 1 : 0;
            check("car_pixel", int'(car_pixel_o), exp_pixel);
            check("hit", int'(hit_o), eh);
            if (eh != 0) check("hit_lane", int'(hit_lane_o), elane);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic pulse_fs();
        cyc();
        frame_start = 1'b1;
        cyc();
        frame_start = 1'b0;
        repeat (6) cyc();
    endtask

    task automatic probe(string name, int h, int v, int exp);
        cyc();
        h_count = 10'(h);
        v_count = 10'(v);
        @(negedge clk);
        check(name, int'(car_pixel_o), exp);
    endtask

    // Call in the cycle where frame_start was just raised. Watches a bounded
    // window; second_at>0 re-raises frame_start that many cycles later.
    task automatic hit_window(string name, int second_at, int exp_cnt, int exp_at, int exp_lane);
        int cnt = 0;
        int at  = -1;
        int ln  = -1;
        for (int i = 1; i <= 14; i++) begin
            @(negedge clk);
            if (hit_o) begin
                cnt++;
                at = i;
                ln = int'(hit_lane_o);
            end
            #1;
            frame_start = (i == second_at) ? 1'b1 : 1'b0;
        end
        check({name, "_count"}, cnt, exp_cnt);
        if (exp_cnt > 0) begin
            check({name, "_cycle"}, at, exp_at);
            check({name, "_lane"}, ln, exp_lane);
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst_n = 1'b1; frame_start = 1'b0; enable = 1'b1;
        h_count = '0; v_count = '0; player_x = '0; player_y = '0;
        lane_dir = '0;
        for (int l = 0; l < NL; l++) begin step_a[l] = 0; div_a[l] = 0; end
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_car_pixel", int'(car_pixel_o), 0);
        check("reset_hit", int'(hit_o), 0);
        check("reset_hit_lane", int'(hit_lane_o), 0);
        chk_en = 1'b1;
        #1 rst_n = 1'b1;

        // Default positions: cars at 0 and 320 in every lane.
        probe("dflt_h10_v330", 10, 330, 1);
        probe("dflt_h100_v330", 100, 330, 0);
        probe("dflt_h10_v300", 10, 300, 0);

        // Lane 0 right by 32 every frame, 19 frames -> 608, span wraps.
        cyc(); lane_dir[0] = 1'b1; step_a[0] = 32;
        repeat (19) pulse_fs();
        check("model_lane0_x", mx[0][0], 608);
        probe("wrap_h20_v330", 20, 330, 1);
        probe("wrap_h600_v330", 600, 330, 0);
        cyc(); step_a[0] = 0;

        // Lane 1 left by 5: 0 -> 635, then hold with enable low.
        lane_dir[1] = 1'b0; step_a[1] = 5;
        pulse_fs();
        check("model_lane1_x", mx[1][0], 635);
        probe("left_h635_v360", 635, 360, 1);
        probe("left_h630_v360", 630, 360, 0);
        cyc(); enable = 1'b0;
        pulse_fs();
        check("model_lane1_hold", mx[1][0], 635);
        probe("hold_h634_v360", 634, 360, 0);
        cyc(); enable = 1'b1; step_a[1] = 0;

        // Lane 2 divider 3: moves on the 4th and 8th frames only.
        lane_dir[2] = 1'b1; step_a[2] = 10; div_a[2] = 3;
        for (int f = 1; f <= 8; f++) begin
            pulse_fs();
            if (f == 3) check("div_f3", mx[2][0], 0);
            if (f == 4) check("div_f4", mx[2][0], 10);
            if (f == 7) check("div_f7", mx[2][0], 10);
            if (f == 8) check("div_f8", mx[2][0], 20);
        end
        probe("div_h19_v390", 19, 390, 0);
        probe("div_h20_v390", 20, 390, 1);
        cyc(); step_a[2] = 0; div_a[2] = 0;

        // Collision scans from default positions.
        rst_n = 1'b0; cyc(); rst_n = 1'b1;
        cyc(); player_x = 10'd16; player_y = 10'd320; frame_start = 1'b1;
        hit_window("hit_16_320", 0, 1, 5, 0);
        cyc(); player_x = 10'd100; player_y = 10'd320; frame_start = 1'b1;
        hit_window("nohit_100_320", 0, 0, 0, 0);
        cyc(); player_x = 10'd16; player_y = 10'd352; frame_start = 1'b1;
        hit_window("hit_16_352", 0, 1, 5, 1);
        cyc(); player_x = 10'd16; player_y = 10'd340; frame_start = 1'b1;
        hit_window("hit_two_lanes", 0, 1, 5, 0);

        // Restart two cycles in: only the second scan reports.
        cyc(); player_x = 10'd16; player_y = 10'd320; frame_start = 1'b1;
        hit_window("restart", 2, 1, 7, 0);

        // Reset mid-scan: no report and cars back at reset positions.
        cyc(); step_a[0] = 32; lane_dir[0] = 1'b1; frame_start = 1'b1;
        cyc(); frame_start = 1'b0;
        cyc(); rst_n = 1'b0;
        cyc(); rst_n = 1'b1;
        begin
            int cnt = 0;
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                if (hit_o) cnt++;
            end
            check("rst_mid_scan_hits", cnt, 0);
        end
        cyc(); step_a[0] = 0;
        probe("rst_h10_v330", 10, 330, 1);
        probe("rst_h70_v330", 70, 330, 0);

        repeat (3) cyc();
        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
